// File: rtl/cfu_req_resp_buffer.sv
// rtl/cfu_req_resp_buffer.sv - CPU/CFU decoupling stage: request skid buffer and credit-gated response FIFO
//
// Modules in this file:
//   cfu_req_skid         two-entry (main + skid) registered request buffer
//   cfu_resp_fifo        circular response FIFO with wrap-bit pointers
//   cfu_req_resp_buffer  top: skid buffer, credit gate, response FIFO
//
// Top-level ports:
//   clk, rst_n        sole clock (rising edge), asynchronous active-low reset
//   s_req_*           CPU-side request: valid/ready, id, cfu select, func, data0, data1
//   s_resp_*          CPU-side response: valid/ready, id, status, data
//   m_req_*           CFU-side request, mirrors s_req_*
//   m_resp_*          CFU-side response; m_resp_ready is constant 1
//   outstanding       ops issued to the CFU and not yet popped by the CPU

// cfu_req_skid: main register feeds the consumer, skid register absorbs the
// one extra accept that can land while in_ready is still high.
//   in_valid/in_ready/in_data      producer side
//   main_valid/main_take/main_data consumer side (main_take only while main_valid)
module cfu_req_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         main_valid,
  input  logic         main_take,
  output logic [W-1:0] main_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;

  // Ready is derived only from the skid flop, never from downstream ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & ~skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (main_take || !main_valid) begin
        // Main is free this edge: the older skid entry wins over a new accept,
        // which cannot happen anyway because in_ready is low while skid is full.
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= accept;
          if (accept) begin
            main_data <= in_data;
          end
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end

endmodule

// cfu_resp_fifo: DEPTH-entry circular buffer, head entry visible combinationally.
//   push/push_data   write side (ignored when full unless popping the same cycle)
//   pop              read side (ignored when empty)
//   empty/full       occupancy flags, head_data is the oldest entry
module cfu_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en     = pop & ~empty;
  // A pop on a full FIFO frees the head slot at the same edge, so the write is safe.
  assign wr_en     = push & (~full | rd_en);
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

module cfu_req_resp_buffer #(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int CFU_W      = 8,
  parameter int FUNC_W     = 7,
  parameter int RESP_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_req_valid,
  output logic                            s_req_ready,
  input  logic [ID_W-1:0]                 s_req_id,
  input  logic [CFU_W-1:0]                s_req_cfu,
  input  logic [FUNC_W-1:0]               s_req_func,
  input  logic [DATA_W-1:0]               s_req_data0,
  input  logic [DATA_W-1:0]               s_req_data1,
  output logic                            s_resp_valid,
  input  logic                            s_resp_ready,
  output logic [ID_W-1:0]                 s_resp_id,
  output logic [2:0]                      s_resp_status,
  output logic [DATA_W-1:0]               s_resp_data,
  output logic                            m_req_valid,
  input  logic                            m_req_ready,
  output logic [ID_W-1:0]                 m_req_id,
  output logic [CFU_W-1:0]                m_req_cfu,
  output logic [FUNC_W-1:0]               m_req_func,
  output logic [DATA_W-1:0]               m_req_data0,
  output logic [DATA_W-1:0]               m_req_data1,
  input  logic                            m_resp_valid,
  input  logic [ID_W-1:0]                 m_resp_id,
  input  logic [2:0]                      m_resp_status,
  input  logic [DATA_W-1:0]               m_resp_data,
  output logic                            m_resp_ready,
  output logic [$clog2(RESP_DEPTH+1)-1:0] outstanding
);

  localparam int OUT_W  = $clog2(RESP_DEPTH + 1);
  localparam int REQ_W  = ID_W + CFU_W + FUNC_W + 2 * DATA_W;
  localparam int RESP_W = ID_W + 3 + DATA_W;
  localparam logic [OUT_W-1:0] CREDITS = OUT_W'(RESP_DEPTH);
  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

  logic              main_valid;
  logic [REQ_W-1:0]  main_data;
  logic              credit_ok;
  logic              req_fire;
  logic              resp_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [RESP_W-1:0] fifo_head;

  cfu_req_skid #(
    .W (REQ_W)
  ) u_req_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_req_valid),
    .in_ready   (s_req_ready),
    .in_data    ({s_req_id, s_req_cfu, s_req_func, s_req_data0, s_req_data1}),
    .main_valid (main_valid),
    .main_take  (req_fire),
    .main_data  (main_data)
  );

  // Every issued op owns a FIFO slot until the CPU pops its response, so the
  // CFU response channel never needs back-pressure.
  assign credit_ok   = (outstanding < CREDITS);
  assign m_req_valid = main_valid & credit_ok;
  assign req_fire    = m_req_valid & m_req_ready;
  assign {m_req_id, m_req_cfu, m_req_func, m_req_data0, m_req_data1} = main_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (req_fire && !resp_pop) begin
      if (outstanding != CREDITS) begin
        outstanding <= outstanding + ONE;
      end
    end else if (resp_pop && !req_fire) begin
      if (outstanding != '0) begin
        outstanding <= outstanding - ONE;
      end
    end
  end

  cfu_resp_fifo #(
    .W     (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (m_resp_valid),
    .push_data ({m_resp_id, m_resp_status, m_resp_data}),
    .pop       (resp_pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head_data (fifo_head)
  );

  assign m_resp_ready = 1'b1;
  assign s_resp_valid = ~fifo_empty;
  assign resp_pop     = s_resp_valid & s_resp_ready;
  assign {s_resp_id, s_resp_status, s_resp_data} = fifo_head;

  // A response into a full FIFO with no simultaneous pop would be dropped.
  a_resp_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) !(m_resp_valid && fifo_full && !resp_pop)
  );

endmodule

// File: tb/tb_cfu_req_resp_buffer.sv
// tb/tb_cfu_req_resp_buffer.sv - self-checking bench for cfu_req_resp_buffer
module tb_cfu_req_resp_buffer;

  localparam int DATA_W     = 32;
  localparam int ID_W       = 4;
  localparam int CFU_W      = 8;
  localparam int FUNC_W     = 7;
  localparam int RESP_DEPTH = 4;
  localparam int OUT_W      = $clog2(RESP_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_req_valid, s_req_ready;
  logic [ID_W-1:0]   s_req_id;
  logic [CFU_W-1:0]  s_req_cfu;
  logic [FUNC_W-1:0] s_req_func;
  logic [DATA_W-1:0] s_req_data0, s_req_data1;
  logic              s_resp_valid, s_resp_ready;
  logic [ID_W-1:0]   s_resp_id;
  logic [2:0]        s_resp_status;
  logic [DATA_W-1:0] s_resp_data;
  logic              m_req_valid, m_req_ready;
  logic [ID_W-1:0]   m_req_id;
  logic [CFU_W-1:0]  m_req_cfu;
  logic [FUNC_W-1:0] m_req_func;
  logic [DATA_W-1:0] m_req_data0, m_req_data1;
  logic              m_resp_valid, m_resp_ready;
  logic [ID_W-1:0]   m_resp_id;
  logic [2:0]        m_resp_status;
  logic [DATA_W-1:0] m_resp_data;
  logic [OUT_W-1:0]  outstanding;

  always #5 clk = ~clk;

  cfu_req_resp_buffer #(
    .DATA_W(DATA_W), .ID_W(ID_W), .CFU_W(CFU_W), .FUNC_W(FUNC_W), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_id(s_req_id),
    .s_req_cfu(s_req_cfu), .s_req_func(s_req_func), .s_req_data0(s_req_data0),
    .s_req_data1(s_req_data1),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_id(s_resp_id),
    .s_resp_status(s_resp_status), .s_resp_data(s_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_id(m_req_id),
    .m_req_cfu(m_req_cfu), .m_req_func(m_req_func), .m_req_data0(m_req_data0),
    .m_req_data1(m_req_data1),
    .m_resp_valid(m_resp_valid), .m_resp_id(m_resp_id), .m_resp_status(m_resp_status),
    .m_resp_data(m_resp_data), .m_resp_ready(m_resp_ready),
    .outstanding(outstanding)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [CFU_W-1:0]  cfu;
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } req_t;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [2:0]        status;
    logic [DATA_W-1:0] data;
  } resp_t;

  typedef struct {
    logic              sv;
    logic [ID_W-1:0]   sid;
    logic [DATA_W-1:0] sd0;
    logic              mrr;
    logic              mrv;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic              srr;
    logic              e_mv;
    logic [ID_W-1:0]   e_mid;
    logic [DATA_W-1:0] e_md0;
    logic              e_sv;
    logic [ID_W-1:0]   e_sid;
    logic [DATA_W-1:0] e_sdata;
    int                e_out;
  } vec_t;

  // Reference model: pending requests (at most two held), response queue,
  // credit count, and the ops the emulated CFU still owes a response for.
  req_t  req_q[$];
  resp_t resp_q[$];
  req_t  cfu_q[$];
  int    m_out;
  int    dut_fires[$];
  int    dut_pops[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    bit exp_mv;
    exp_mv = (req_q.size() > 0) && (m_out < RESP_DEPTH);
    check("s_req_ready", s_req_ready, req_q.size() < 2);
    check("m_req_valid", m_req_valid, exp_mv);
    if (exp_mv) begin
      check("m_req_id", m_req_id, req_q[0].id);
      check("m_req_cfu", m_req_cfu, req_q[0].cfu);
      check("m_req_func", m_req_func, req_q[0].func);
      check("m_req_data0", m_req_data0, req_q[0].d0);
      check("m_req_data1", m_req_data1, req_q[0].d1);
    end
    check("s_resp_valid", s_resp_valid, resp_q.size() > 0);
    if (resp_q.size() > 0) begin
      check("s_resp_id", s_resp_id, resp_q[0].id);
      check("s_resp_status", s_resp_status, resp_q[0].status);
      check("s_resp_data", s_resp_data, resp_q[0].data);
    end
    check("outstanding", outstanding, m_out);
    check("m_resp_ready", m_resp_ready, 1);
  endtask

  // Advance one clock: update the model from the current inputs, record what
  // the DUT handshakes, then check all outputs after the edge.
  task automatic step();
    bit    mv, fire, acc, pop, push;
    req_t  r;
    resp_t p;
    mv   = (req_q.size() > 0) && (m_out < RESP_DEPTH);
    fire = mv && m_req_ready;
    acc  = s_req_valid && (req_q.size() < 2);
    pop  = (resp_q.size() > 0) && s_resp_ready;
    push = m_resp_valid && ((resp_q.size() < RESP_DEPTH) || pop);
    if (m_req_valid && m_req_ready) dut_fires.push_back(int'(m_req_id));
    if (s_resp_valid && s_resp_ready) dut_pops.push_back(int'(s_resp_id));
    if (pop) resp_q.delete(0);
    if (push) begin
      p.id = m_resp_id; p.status = m_resp_status; p.data = m_resp_data;
      resp_q.push_back(p);
    end
    if (fire) begin
      cfu_q.push_back(req_q[0]);
      req_q.delete(0);
    end
    if (acc) begin
      r.id = s_req_id; r.cfu = s_req_cfu; r.func = s_req_func;
      r.d0 = s_req_data0; r.d1 = s_req_data1;
      req_q.push_back(r);
    end
    if (fire && !pop && m_out < RESP_DEPTH) m_out++;
    else if (pop && !fire && m_out > 0) m_out--;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic model_clear();
    req_q.delete(); resp_q.delete(); cfu_q.delete();
    dut_fires.delete(); dut_pops.delete();
    m_out = 0;
  endtask

  task automatic set_req(input bit v, input int id);
    s_req_valid = v;
    s_req_id    = ID_W'(id);
    s_req_cfu   = CFU_W'(id * 3);
    s_req_func  = FUNC_W'(id + 1);
    s_req_data0 = DATA_W'(32'h9E3779B9 * id);
    s_req_data1 = ~DATA_W'(32'h7F4A7C15 * id);
  endtask

  task automatic cfu_respond(input bit en);
    if (en && cfu_q.size() > 0) begin
      m_resp_valid  = 1'b1;
      m_resp_id     = cfu_q[0].id;
      m_resp_status = cfu_q[0].func[2:0];
      m_resp_data   = cfu_q[0].d0 ^ cfu_q[0].d1 ^ 32'h5A5A0000;
      cfu_q.delete(0);
    end else begin
      m_resp_valid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    set_req(1'b0, 0);
    s_resp_ready = 1'b0; m_req_ready = 1'b0;
    m_resp_valid = 1'b0; m_resp_id = '0; m_resp_status = '0; m_resp_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int   nid;
    int   exp_order[8];

    vt[0] = '{1'b1, 4'd3, 32'h6A09E667, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1,
              1'b1, 4'd3, 32'h6A09E667, 1'b0, 4'd0, 32'h0, 0};
    vt[1] = '{1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1,
              1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1};
    vt[2] = '{1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 4'd3, 32'hCAFEBABE, 1'b1,
              1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'hCAFEBABE, 1};
    vt[3] = '{1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1,
              1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 0};

    // Reset state
    reset_dut();
    check("reset s_req_ready", s_req_ready, 1);
    check("reset m_req_valid", m_req_valid, 0);
    check("reset s_resp_valid", s_resp_valid, 0);
    check("reset outstanding", outstanding, 0);

    // Single op, table driven
    s_req_cfu = '0; s_req_func = '0; s_req_data1 = '0; m_resp_status = '0;
    for (int i = 0; i < 4; i++) begin
      s_req_valid = vt[i].sv; s_req_id = vt[i].sid; s_req_data0 = vt[i].sd0;
      m_req_ready = vt[i].mrr; m_resp_valid = vt[i].mrv; m_resp_id = vt[i].rid;
      m_resp_data = vt[i].rdata; s_resp_ready = vt[i].srr;
      step();
      check("tbl m_req_valid", m_req_valid, vt[i].e_mv);
      if (vt[i].e_mv) begin
        check("tbl m_req_id", m_req_id, vt[i].e_mid);
        check("tbl m_req_data0", m_req_data0, vt[i].e_md0);
      end
      check("tbl s_resp_valid", s_resp_valid, vt[i].e_sv);
      if (vt[i].e_sv) begin
        check("tbl s_resp_id", s_resp_id, vt[i].e_sid);
        check("tbl s_resp_data", s_resp_data, vt[i].e_sdata);
      end
      check("tbl outstanding", outstanding, vt[i].e_out);
    end

    // Credit limit: six requests, CPU not popping
    reset_dut();
    m_req_ready = 1'b1; s_resp_ready = 1'b0; nid = 0;
    for (int c = 0; c < 14; c++) begin
      if (nid < 6) set_req(1'b1, nid); else s_req_valid = 1'b0;
      cfu_respond(1'b1);
      if (nid < 6 && req_q.size() < 2) nid++;
      step();
    end
    check("credit fires", dut_fires.size(), 4);
    check("credit m_req_valid", m_req_valid, 0);
    check("credit outstanding", outstanding, 4);
    check("credit s_req_ready", s_req_ready, 0);
    check("credit s_resp_valid", s_resp_valid, 1);
    s_resp_ready = 1'b1;
    for (int c = 0; c < 40 && dut_pops.size() < 6; c++) begin
      cfu_respond(1'b1);
      step();
    end
    check("credit pop count", dut_pops.size(), 6);
    for (int i = 0; i < 6 && i < dut_pops.size(); i++) check("credit pop order", dut_pops[i], i);

    // Skid: A, B accepted under back-pressure, C stalled
    reset_dut();
    m_req_ready = 1'b0; nid = 0;
    for (int c = 0; c < 3; c++) begin
      set_req(1'b1, 10 + nid);
      if (req_q.size() < 2) nid++;
      step();
    end
    check("skid s_req_ready", s_req_ready, 0);
    check("skid m_req_id", m_req_id, 10);
    check("skid no fires", dut_fires.size(), 0);
    m_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (nid < 3) set_req(1'b1, 10 + nid); else s_req_valid = 1'b0;
      if (nid < 3 && req_q.size() < 2) nid++;
      step();
    end
    check("skid fire count", dut_fires.size(), 3);
    for (int i = 0; i < 3 && i < dut_fires.size(); i++) check("skid fire order", dut_fires[i], 10 + i);

    // Full FIFO with simultaneous push and pop, across the pointer wrap
    reset_dut();
    m_req_ready = 1'b1; nid = 0;
    for (int c = 0; c < 10; c++) begin
      if (nid < 4) set_req(1'b1, nid); else s_req_valid = 1'b0;
      cfu_respond(1'b1);
      if (nid < 4 && req_q.size() < 2) nid++;
      step();
    end
    s_resp_ready = 1'b1; cfu_respond(1'b0);
    step();
    s_resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (nid < 5) set_req(1'b1, nid); else s_req_valid = 1'b0;
      cfu_respond(1'b1);
      if (nid < 5 && req_q.size() < 2) nid++;
      step();
    end
    check("full outstanding", outstanding, 4);
    check("full head id", s_resp_id, 1);
    for (int k = 0; k < 3; k++) begin
      s_resp_ready = 1'b1; m_resp_valid = 1'b1;
      m_resp_id = ID_W'(9 + k); m_resp_status = 3'd5; m_resp_data = 32'hF00D0000 + k;
      step();
      check("full s_resp_valid", s_resp_valid, 1);
      check("full head after push+pop", s_resp_id, 2 + k);
    end
    m_resp_valid = 1'b0;
    for (int c = 0; c < 10; c++) step();
    exp_order = '{0, 1, 2, 3, 4, 9, 10, 11};
    check("full pop count", dut_pops.size(), 8);
    for (int i = 0; i < 8 && i < dut_pops.size(); i++) check("full pop order", dut_pops[i], exp_order[i]);

    // Asynchronous reset mid-cycle with ops in flight and skid full
    reset_dut();
    m_req_ready = 1'b1; nid = 0;
    for (int c = 0; c < 6; c++) begin
      if (nid < 3) set_req(1'b1, nid); else s_req_valid = 1'b0;
      cfu_respond(c == 5);
      if (nid < 3 && req_q.size() < 2) nid++;
      step();
    end
    m_req_ready = 1'b0; m_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (nid < 5) set_req(1'b1, nid); else s_req_valid = 1'b0;
      if (nid < 5 && req_q.size() < 2) nid++;
      step();
    end
    check("pre-reset outstanding", outstanding, 3);
    check("pre-reset s_req_ready", s_req_ready, 0);
    check("pre-reset s_resp_valid", s_resp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst m_req_valid", m_req_valid, 0);
    check("async rst s_resp_valid", s_resp_valid, 0);
    check("async rst outstanding", outstanding, 0);
    check("async rst s_req_ready", s_req_ready, 1);
    set_req(1'b0, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    set_req(1'b1, 7); m_req_ready = 1'b1;
    step();
    check("post-reset m_req_valid", m_req_valid, 1);
    check("post-reset m_req_id", m_req_id, 7);
    s_req_valid = 1'b0;
    step();
    check("post-reset outstanding", outstanding, 1);

    // Randomized traffic against the model
    reset_dut();
    for (int c = 0; c < 800; c++) begin
      bit acc;
      if (!s_req_valid && ($urandom % 3 != 0)) begin
        s_req_valid = 1'b1;
        s_req_id = ID_W'($urandom); s_req_cfu = CFU_W'($urandom);
        s_req_func = FUNC_W'($urandom); s_req_data0 = $urandom; s_req_data1 = $urandom;
      end
      m_req_ready  = ($urandom % 4 != 0);
      s_resp_ready = ($urandom % 2 != 0);
      cfu_respond($urandom % 2 != 0);
      acc = s_req_valid && (req_q.size() < 2);
      step();
      if (acc) s_req_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfu_req_resp_buffer.md
# cfu_req_resp_buffer

Decoupling stage placed between the CPU's CFU port and the CFU, which holds the SHA-256/CRC function units. Requests pass through a registered two-entry skid buffer. Responses land in a credit-protected FIFO, so the CFU's response channel is never back-pressured. The CPU may stall on responses without blocking new request issue, up to `RESP_DEPTH` outstanding operations.

## Interface
Parameters:
- `DATA_W`, 32, width of `req_data0`, `req_data1` and `resp_data`
- `ID_W`, 4, width of the request/response id
- `CFU_W`, 8, width of `req_cfu` (CFU select)
- `FUNC_W`, 7, width of `req_func`
- `RESP_DEPTH`, 4, response FIFO entries and maximum outstanding ops; power of two, ≥2

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_req_valid` / `s_req_ready`  in / out  1  CPU-side request handshake
- `s_req_id`, `s_req_cfu`, `s_req_func`  in  ID_W, CFU_W, FUNC_W  request tag, CFU select and function code
- `s_req_data0`, `s_req_data1`  in  DATA_W  operands
- `s_resp_valid` / `s_resp_ready`  out / in  1  CPU-side response handshake
- `s_resp_id`, `s_resp_status`, `s_resp_data`  out  ID_W, 3, DATA_W  response to CPU
- `m_req_*`  out (ready in)  same widths  CFU-side request, mirrors `s_req_*`
- `m_resp_valid`  in  1  CFU response valid
- `m_resp_id`, `m_resp_status`, `m_resp_data`  in  ID_W, 3, DATA_W  CFU response payload
- `m_resp_ready`  out  1  tied to 1
- `outstanding`  out  $clog2(RESP_DEPTH+1)  ops issued to the CFU and not yet popped by the CPU

## Operation
- **Request skid buffer.** It holds a main register and a skid register.
  - `s_req_ready` is a register: 1 when the skid register is empty.
  - An accept while main is empty, or while main fires the same cycle, loads main.
  - An accept while main is held loads skid.
  - When main fires, skid (if full) moves into main.
- **Credit gate.**
  - `m_req_valid = main_valid & (outstanding < RESP_DEPTH)`.
  - A fire on the CFU side (`m_req_valid & m_req_ready`) increments `outstanding`.
  - A CPU pop (`s_resp_valid & s_resp_ready`) decrements it.
  - Both in the same cycle leave it unchanged.
  - It never exceeds `RESP_DEPTH` and never underflows.
- **Response FIFO.** A circular buffer of `RESP_DEPTH` entries holding {id, status, data}.
  - Read and write pointers are `$clog2(RESP_DEPTH)+1` bits, with the extra wrap bit.
  - Full when the low bits are equal and the wrap bits differ; empty when the pointers are equal.
  - Every `m_resp_valid` cycle pushes; the credit gate guarantees space, so overflow is impossible by construction.
  - `s_resp_valid = !empty`; the payload is read from the head entry.
  - Responses are delivered in the order the CFU returns them. Ids pass through unmodified; no reordering.
- **Debug assertion.** An `m_resp_valid` arriving while the FIFO is full is a protocol error and must fire an assertion (simulation only).
- **Reset (`rst_n` low, any time).**
  - Immediately clears all valids, `outstanding`, both pointers and both skid entries.
  - `s_req_ready` goes to 1; `s_resp_valid` and `m_req_valid` go to 0.
  - Payload registers reset to 0.
  - In-flight ops are discarded. The CFU must share this reset.

## Timing
- Request latency: accepted at edge N → visible on `m_req_*` after edge N (cycle N+1), if main was empty and credit is available.
- Sustained throughput: 1 request/cycle with `m_req_ready` held high.
- `s_req_ready` drops the cycle after skid fills. No request is lost: main ready-low plus one more accept is absorbed by skid.
- Response latency: `m_resp_valid` at edge N → `s_resp_valid` high in cycle N+1 (no bypass).
- FIFO push and pop in the same cycle are both performed, including when the FIFO holds `RESP_DEPTH` entries.
- Credit release: a pop at edge N allows `m_req_valid` to rise in cycle N+1.
- No combinational path from any `s_*` input to any `m_*` output, or the reverse.

## Test plan
- **Single op.** Request id=3, func=0, data0=0x6A09E667 with `m_req_ready=1` → appears on `m_req` after 1 cycle. CFU returns data=0xCAFEBABE, id=3 → `s_resp` shows id=3, data=0xCAFEBABE one cycle later; `outstanding` goes 0→1→0.
- **Credit limit.** `RESP_DEPTH=4`, `s_resp_ready=0`, 6 back-to-back requests with the CFU responding each cycle → exactly 4 fires on `m_req`; `m_req_valid` is 0 while `outstanding=4`. The 5th and 6th sit in main/skid and `s_req_ready=0`. Releasing `s_resp_ready` delivers ids 0..5 in order.
- **Skid.** `m_req_ready=0` for 3 cycles while requests A, B, C are offered → A and B accepted, C stalled by `s_req_ready=0`. Then `m_req_ready=1` → A, B, C reach the CFU in order, none duplicated.
- **Full push+pop.** FIFO holds 4 entries; in the same cycle pop with `s_resp_ready=1` and push a new response (credit permits it after a prior pop) → count stays 4, order preserved, pointer wrap correct.
- **Mid-operation reset.** `rst_n` pulsed low asynchronously (mid-cycle) with 3 outstanding and the skid full → all valids 0 and `outstanding=0` immediately, `s_req_ready=1`. Normal operation resumes on the first edge after release.
